// File: rtl/hazard_scheduler_if.sv
// hazard_scheduler_if
// Bundles the hazard inputs from the pipeline stages and the per-stage
// control outputs of hazard_scheduler.
//   Hazard inputs  : rs1_ID, rs2_ID, rd_EX, MemRead_EX, redirect_EX,
//                    mdu_start_EX, mdu_done, dmem_req_MEM, dmem_ready
//   Control outputs: PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush,
//                    IDEXFlush, EXMEMBubble, MEMWBBubble, mdu_abort
//   Counters       : stall_cycles, flush_events (CNT_W bits, saturating)
// The slave modport is the scheduler side; the master modport is the
// pipeline side that supplies hazards and consumes controls.
interface hazard_scheduler_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic [4:0]       rd_EX;
    logic             MemRead_EX;
    logic             redirect_EX;
    logic             mdu_start_EX;
    logic             mdu_done;
    logic             dmem_req_MEM;
    logic             dmem_ready;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IDEXWrite;
    logic             EXMEMWrite;
    logic             IFIDFlush;
    logic             IDEXFlush;
    logic             EXMEMBubble;
    logic             MEMWBBubble;
    logic             mdu_abort;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport slave (
        input  rs1_ID, rs2_ID, rd_EX, MemRead_EX, redirect_EX,
               mdu_start_EX, mdu_done, dmem_req_MEM, dmem_ready,
        output PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush,
               IDEXFlush, EXMEMBubble, MEMWBBubble, mdu_abort,
               stall_cycles, flush_events
    );

    modport master (
        output rs1_ID, rs2_ID, rd_EX, MemRead_EX, redirect_EX,
               mdu_start_EX, mdu_done, dmem_req_MEM, dmem_ready,
        input  PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush,
               IDEXFlush, EXMEMBubble, MEMWBBubble, mdu_abort,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_scheduler.sv
// hazard_scheduler
// Pipeline-control block for the 5-stage core. Merges data-memory wait,
// multi-cycle MUL/DIV, branch/jump redirect and load-use hazards into
// per-stage write enables and flush/bubble controls.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : hazard_scheduler_if.slave (hazard inputs, stage controls,
//           saturating stall/flush counters)
// Priority every cycle: mem-wait > MDU > redirect > load-use.
// Control outputs are combinational from the state register and inputs;
// state, watchdog and counters are registered.
module hazard_scheduler #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_scheduler_if.slave    bus
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_MDU_WAIT = 2'd2;

    localparam logic [7:0]       WD_LIMIT = 8'(MDU_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    // Remembers that a mem-wait interrupted MDU_WAIT, so release goes back there.
    logic             ret_mdu_q, ret_mdu_d;
    logic [7:0]       wd_q, wd_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic mem_wait_s;
    logic load_use_s;
    logic mdu_busy_s;
    logic pc_we_s, ifid_we_s, idex_we_s, exmem_we_s;
    logic ifid_fl_s, idex_fl_s, exmem_bub_s, memwb_bub_s, abort_s;

    assign mem_wait_s = bus.dmem_req_MEM & ~bus.dmem_ready;
    assign mdu_busy_s = bus.mdu_start_EX & ~bus.mdu_done;
    assign load_use_s = bus.MemRead_EX & (bus.rd_EX != 5'd0) &
                        ((bus.rd_EX == bus.rs1_ID) | (bus.rd_EX == bus.rs2_ID));

    // Control decode and FSM / watchdog next-state.
    always_comb begin
        pc_we_s     = 1'b1;
        ifid_we_s   = 1'b1;
        idex_we_s   = 1'b1;
        exmem_we_s  = 1'b1;
        ifid_fl_s   = 1'b0;
        idex_fl_s   = 1'b0;
        exmem_bub_s = 1'b0;
        memwb_bub_s = 1'b0;
        abort_s     = 1'b0;
        state_d     = state_q;
        ret_mdu_d   = ret_mdu_q;
        wd_d        = wd_q;

        if (mem_wait_s) begin
            // Whole front of the pipe freezes; watchdog holds its value.
            pc_we_s     = 1'b0;
            ifid_we_s   = 1'b0;
            idex_we_s   = 1'b0;
            exmem_we_s  = 1'b0;
            memwb_bub_s = 1'b1;
            state_d     = ST_MEM_WAIT;
            if (state_q == ST_MDU_WAIT) begin
                ret_mdu_d = 1'b1;
            end else if (state_q == ST_MEM_WAIT) begin
                ret_mdu_d = ret_mdu_q;
            end else begin
                ret_mdu_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mdu_busy_s) begin
                        pc_we_s     = 1'b0;
                        ifid_we_s   = 1'b0;
                        idex_we_s   = 1'b0;
                        exmem_bub_s = 1'b1;
                        state_d     = ST_MDU_WAIT;
                        wd_d        = 8'd0;
                    end else if (bus.redirect_EX) begin
                        // ID holds a wrong-path instruction, so any load-use stall is moot.
                        ifid_fl_s = 1'b1;
                        idex_fl_s = 1'b1;
                    end else if (load_use_s) begin
                        pc_we_s   = 1'b0;
                        ifid_we_s = 1'b0;
                        idex_fl_s = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MDU_WAIT: begin
                    if (bus.mdu_done) begin
                        state_d = ST_RUN;
                    end else if (wd_q == WD_LIMIT) begin
                        // Watchdog: release the pipe, discard the op via the bubble.
                        abort_s     = 1'b1;
                        exmem_bub_s = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        pc_we_s     = 1'b0;
                        ifid_we_s   = 1'b0;
                        idex_we_s   = 1'b0;
                        exmem_bub_s = 1'b1;
                        wd_d        = wd_q + 8'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    // Memory released this cycle; resume whatever was interrupted.
                    ret_mdu_d = 1'b0;
                    if (ret_mdu_q && !bus.mdu_done) begin
                        pc_we_s     = 1'b0;
                        ifid_we_s   = 1'b0;
                        idex_we_s   = 1'b0;
                        exmem_bub_s = 1'b1;
                        state_d     = ST_MDU_WAIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d   = ST_RUN;
                    ret_mdu_d = 1'b0;
                    wd_d      = 8'd0;
                end
            endcase
        end
    end

    // Saturating performance-counter next-state.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_we_s && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
        if (ifid_fl_s && (flush_q != CNT_MAX)) begin
            flush_d = flush_q + CNT_ONE;
        end else begin
            flush_d = flush_q;
        end
    end

    // State, watchdog and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            ret_mdu_q <= 1'b0;
            wd_q      <= 8'd0;
            stall_q   <= {CNT_W{1'b0}};
            flush_q   <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            ret_mdu_q <= ret_mdu_d;
            wd_q      <= wd_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    // While reset is asserted the pipe sees plain RUN defaults regardless of inputs.
    assign bus.PCWrite      = pc_we_s    | ~rst_n;
    assign bus.IFIDWrite    = ifid_we_s  | ~rst_n;
    assign bus.IDEXWrite    = idex_we_s  | ~rst_n;
    assign bus.EXMEMWrite   = exmem_we_s | ~rst_n;
    assign bus.IFIDFlush    = ifid_fl_s   & rst_n;
    assign bus.IDEXFlush    = idex_fl_s   & rst_n;
    assign bus.EXMEMBubble  = exmem_bub_s & rst_n;
    assign bus.MEMWBBubble  = memwb_bub_s & rst_n;
    assign bus.mdu_abort    = abort_s     & rst_n;
    assign bus.stall_cycles = stall_q;
    assign bus.flush_events = flush_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler (MDU_TIMEOUT = 8, CNT_W = 16).
// Control vector order: {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
//                        IFIDFlush, IDEXFlush, EXMEMBubble, MEMWBBubble, mdu_abort}
module tb_hazard_scheduler;

    localparam logic [8:0] C_DEF   = 9'b111100000;
    localparam logic [8:0] C_LU    = 9'b001101000;
    localparam logic [8:0] C_RED   = 9'b111111000;
    localparam logic [8:0] C_MDU   = 9'b000100100;
    localparam logic [8:0] C_MEMW  = 9'b000000010;
    localparam logic [8:0] C_ABORT = 9'b111100101;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    hazard_scheduler_if #(.CNT_W(16)) bus ();

    hazard_scheduler #(.MDU_TIMEOUT(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ctl();
        return {bus.PCWrite, bus.IFIDWrite, bus.IDEXWrite, bus.EXMEMWrite,
                bus.IFIDFlush, bus.IDEXFlush, bus.EXMEMBubble, bus.MEMWBBubble,
                bus.mdu_abort};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [8:0] expv);
        #1;
        chk(tag, {23'd0, ctl()}, {23'd0, expv});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rs1_ID       = 5'd0;
        bus.rs2_ID       = 5'd0;
        bus.rd_EX        = 5'd0;
        bus.MemRead_EX   = 1'b0;
        bus.redirect_EX  = 1'b0;
        bus.mdu_start_EX = 1'b0;
        bus.mdu_done     = 1'b0;
        bus.dmem_req_MEM = 1'b0;
        bus.dmem_ready   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();

        // Reset state
        chk_ctl("reset_ctl", C_DEF);
        chk("reset_stall", 32'(bus.stall_cycles), 32'd0);
        chk("reset_flush", 32'(bus.flush_events), 32'd0);

        // Redirect together with a load-use hazard: redirect wins
        bus.redirect_EX = 1'b1;
        bus.MemRead_EX  = 1'b1;
        bus.rd_EX       = 5'd5;
        bus.rs2_ID      = 5'd5;
        chk_ctl("redirect_lu_ctl", C_RED);
        tick();
        clear_inputs();
        chk("redirect_flush", 32'(bus.flush_events), 32'd1);
        chk("redirect_stall", 32'(bus.stall_cycles), 32'd0);

        // Load-use on rs2
        bus.MemRead_EX = 1'b1;
        bus.rd_EX      = 5'd5;
        bus.rs2_ID     = 5'd5;
        chk_ctl("lu_rs2_ctl", C_LU);
        tick();
        clear_inputs();
        chk_ctl("lu_after_ctl", C_DEF);
        chk("lu_stall", 32'(bus.stall_cycles), 32'd1);

        // Load into x0 never stalls
        bus.MemRead_EX = 1'b1;
        bus.rd_EX      = 5'd0;
        chk_ctl("lu_x0_ctl", C_DEF);
        tick();
        clear_inputs();
        chk("lu_x0_stall", 32'(bus.stall_cycles), 32'd1);

        // Load-use on rs1
        bus.MemRead_EX = 1'b1;
        bus.rd_EX      = 5'd7;
        bus.rs1_ID     = 5'd7;
        bus.rs2_ID     = 5'd3;
        chk_ctl("lu_rs1_ctl", C_LU);
        tick();
        clear_inputs();
        chk("lu_rs1_stall", 32'(bus.stall_cycles), 32'd2);

        // MDU op, done 4 cycles after start: 4 stall cycles
        bus.mdu_start_EX = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_ctl($sformatf("mdu_stall_%0d", i), C_MDU);
            tick();
        end
        bus.mdu_done = 1'b1;
        chk_ctl("mdu_done_ctl", C_DEF);
        tick();
        clear_inputs();
        bus.redirect_EX = 1'b1;
        chk_ctl("mdu_back_to_run", C_RED);
        tick();
        clear_inputs();
        chk("mdu_stall_cnt", 32'(bus.stall_cycles), 32'd6);
        chk("mdu_flush_cnt", 32'(bus.flush_events), 32'd2);

        // MDU that finishes in the same cycle it starts: no stall
        bus.mdu_start_EX = 1'b1;
        bus.mdu_done     = 1'b1;
        chk_ctl("mdu_instant_ctl", C_DEF);
        tick();
        clear_inputs();
        chk("mdu_instant_stall", 32'(bus.stall_cycles), 32'd6);

        // Mem-wait for 3 cycles starting at MDU stall cycle 2; watchdog frozen
        bus.mdu_start_EX = 1'b1;
        chk_ctl("mw_mdu_c0", C_MDU);
        tick();
        chk_ctl("mw_mdu_c1", C_MDU);
        tick();
        bus.dmem_req_MEM = 1'b1;
        bus.dmem_ready   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_ctl($sformatf("mw_wait_%0d", i), C_MEMW);
            tick();
        end
        bus.dmem_ready = 1'b1;
        tick();
        bus.dmem_req_MEM = 1'b0;
        bus.dmem_ready   = 1'b0;
        // Watchdog was 1 when frozen; six more MDU_WAIT cycles reach 7
        for (int i = 0; i < 6; i++) begin
            chk_ctl($sformatf("mw_resume_%0d", i), C_MDU);
            tick();
        end
        chk_ctl("mw_abort_ctl", C_ABORT);
        tick();
        clear_inputs();
        bus.redirect_EX = 1'b1;
        chk_ctl("mw_abort_run", C_RED);
        tick();
        clear_inputs();

        // Reset between sections clears the counters
        rst_n = 1'b0;
        #1;
        chk("rst2_stall", 32'(bus.stall_cycles), 32'd0);
        chk("rst2_flush", 32'(bus.flush_events), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();

        // Clean watchdog: abort on the 8th MDU_WAIT cycle
        bus.mdu_start_EX = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_ctl($sformatf("wd_stall_%0d", i), C_MDU);
            tick();
        end
        chk_ctl("wd_abort_ctl", C_ABORT);
        tick();
        clear_inputs();
        bus.redirect_EX = 1'b1;
        chk_ctl("wd_run_next", C_RED);
        tick();
        clear_inputs();
        chk("wd_stall_cnt", 32'(bus.stall_cycles), 32'd8);
        chk("wd_flush_cnt", 32'(bus.flush_events), 32'd1);

        // Saturate stall counter with a long memory wait
        bus.dmem_req_MEM = 1'b1;
        bus.dmem_ready   = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        chk("sat_stall", 32'(bus.stall_cycles), 32'h0000FFFF);
        bus.dmem_ready = 1'b1;
        chk_ctl("sat_release_ctl", C_DEF);
        tick();
        clear_inputs();

        // Async reset in the middle of MDU_WAIT
        bus.mdu_start_EX = 1'b1;
        tick();
        tick();
        chk_ctl("pre_rst_mdu", C_MDU);
        #2;
        rst_n = 1'b0;
        chk_ctl("async_rst_ctl", C_DEF);
        chk("async_rst_stall", 32'(bus.stall_cycles), 32'd0);
        chk("async_rst_flush", 32'(bus.flush_events), 32'd0);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        bus.redirect_EX = 1'b1;
        chk_ctl("post_rst_run", C_RED);
        tick();
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Sequential pipeline-control block for the 5-stage RISC-V core. Arbitrates all stall and flush sources (data-memory wait, multi-cycle MUL/DIV unit, taken branch/jump redirect, load-use hazard) into per-stage write-enable and flush controls. Runs a small FSM with an MDU watchdog and saturating performance counters. It sits beside the forwarding unit and drives the PC, IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
Parameters:
- `MDU_TIMEOUT`, default 64: maximum number of cycles spent in MDU_WAIT before a forced abort; range 2..255.
- `CNT_W`, default 16: width of each performance counter.

Ports:
- `clk` — in, 1: single system clock, rising edge.
- `rst_n` — in, 1: asynchronous reset, active-low.
- `rs1_ID`, `rs2_ID` — in, 5 each: source registers of the instruction in ID.
- `rd_EX` — in, 5: destination register of the instruction in EX.
- `MemRead_EX` — in, 1: the instruction in EX is a load.
- `redirect_EX` — in, 1: taken branch or jump resolved in EX.
- `mdu_start_EX` — in, 1: the instruction in EX is a multi-cycle MUL/DIV. Held while the instruction sits in EX.
- `mdu_done` — in, 1: MDU result valid. Level signal, held until EX advances.
- `dmem_req_MEM` — in, 1: the instruction in MEM accesses data memory.
- `dmem_ready` — in, 1: data-memory access completes this cycle.
- `PCWrite`, `IFIDWrite`, `IDEXWrite`, `EXMEMWrite` — out, 1 each: stage write enables.
- `IFIDFlush`, `IDEXFlush`, `EXMEMBubble`, `MEMWBBubble` — out, 1 each: insert a NOP into that register on this edge.
- `mdu_abort` — out, 1: one-cycle pulse when the watchdog fires.
- `stall_cycles`, `flush_events` — out, `CNT_W` each: saturating counters.

## Operation
- States: RUN, MEM_WAIT, MDU_WAIT. Reset state is RUN.
- Default output values (RUN, no hazard): all `*Write` signals = 1; all flush/bubble signals = 0; `mdu_abort` = 0.
- Hazard priority, evaluated every cycle: mem-wait > MDU > redirect > load-use.
- **Mem-wait** (`dmem_req_MEM & !dmem_ready`, any state):
  - PCWrite, IFIDWrite, IDEXWrite and EXMEMWrite are 0.
  - MEMWBBubble is 1.
  - State goes to MEM_WAIT. The state returns to RUN when `dmem_ready`, and on that cycle the outputs take RUN values.
  - If the FSM was in MDU_WAIT, it returns to MDU_WAIT instead of RUN.
- **MDU**: in RUN, when `mdu_start_EX & !mdu_done`:
  - PCWrite, IFIDWrite and IDEXWrite are 0; EXMEMBubble is 1.
  - Next state is MDU_WAIT.
  - In MDU_WAIT, the same outputs hold until `mdu_done`. On the `mdu_done` cycle the outputs take RUN values and the next state is RUN.
  - If `mdu_start_EX & mdu_done` in RUN: no stall.
- **Redirect** (RUN, no higher-priority hazard): IFIDFlush = 1 and IDEXFlush = 1. This overrides any load-use stall, because the ID instruction is on the wrong path.
- **Load-use** (RUN only): condition is `MemRead_EX & rd_EX != 0 & (rd_EX == rs1_ID | rd_EX == rs2_ID)`.
  - PCWrite = 0, IFIDWrite = 0, IDEXFlush = 1.
  - Purely combinational; lasts exactly one cycle because the load then leaves EX.
- **Watchdog**:
  - An 8-bit counter clears on entry to MDU_WAIT and increments on each cycle spent in MDU_WAIT; it is frozen while in MEM_WAIT.
  - When the count reaches `MDU_TIMEOUT - 1` without `mdu_done`, `mdu_abort` pulses for 1 cycle and all `*Write` signals are 1.
  - EXMEMBubble stays 1, so the op is discarded, and the next state is RUN.
- **Counters**:
  - `stall_cycles` increments on every cycle with PCWrite = 0.
  - `flush_events` increments on every cycle with IFIDFlush = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- State, watchdog counter and performance counters are registered. Control outputs are combinational from state and inputs, with no added latency.
- Load-use adds 1 bubble cycle. Redirect costs 2 squashed instructions. An MDU op needing N cycles (done asserted N−1 cycles after start) stalls N−1 cycles.
- Asynchronous reset, including mid-stall:
  - State returns to RUN; watchdog and both counters return to 0; `mdu_abort` = 0.
  - Outputs immediately take RUN default values.
- Mem-wait during MDU_WAIT: the watchdog freezes and EXMEMWrite = 0 dominates.

## Test plan
- Load-use: `MemRead_EX=1`, `rd_EX=5`, `rs2_ID=5` for 1 cycle -> PCWrite=0, IFIDWrite=0, IDEXFlush=1 for that cycle only; `stall_cycles`=1. Repeat with `rd_EX=0` -> no stall.
- Redirect with simultaneous load-use -> IFIDFlush=1, IDEXFlush=1, PCWrite=1; `flush_events`=1, `stall_cycles`=0.
- MDU: `mdu_start_EX=1`, `mdu_done` rises 4 cycles later -> PCWrite=0 for 4 cycles and EXMEMBubble=1 in each of them; state RUN after done; `stall_cycles`=4.
- Mem-wait inside MDU_WAIT: `dmem_ready` low for 3 cycles at stall cycle 2 -> all writes 0, MEMWBBubble=1 for 3 cycles; state returns to MDU_WAIT; watchdog holds its value.
- Watchdog with `MDU_TIMEOUT=8` and `mdu_done` never asserted -> `mdu_abort` pulses at the 8th MDU_WAIT cycle, EXMEMBubble=1, state RUN next cycle.
- Assert `rst_n=0` mid-MDU_WAIT with `stall_cycles`=0xFFFF (saturated) -> state RUN, all counters 0, PCWrite=1 immediately without a clock edge.
